// File: rtl/cpu_pkg.sv
// Shared CPU constants and the imem loader state type; the RV32I decoder uses the same encodings.
// With IMEM_LOADER_PAD_EN defined, the loader state type gains the PAD state.
package cpu_pkg;

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [2:0]  F3_ADDI  = 3'b000;
  localparam logic [2:0]  ALU_NOP  = 3'd0;
  localparam logic [2:0]  ALU_ADDI = 3'd1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef IMEM_LOADER_PAD_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_PAD  = 2'd3
  } loader_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } loader_state_t;
`endif

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder for loader commands; the inverse of the control decoder.
// valid is low for alu_op values with no encoding.
module instr_encode
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [11:0] imm12,
  output logic [31:0] word,
  output logic        valid
);

  always_comb begin
    word  = '0;
    valid = 1'b0;
    case (op)
      ALU_NOP: begin
        word  = NOP_WORD;
        valid = 1'b1;
      end
      ALU_ADDI: begin
        word  = {imm12, rs1, F3_ADDI, rd, OP_IMM};
        valid = 1'b1;
      end
      default: begin
        word  = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded instruction commands into instruction memory, one word per cycle from address 0.
// Define IMEM_LOADER_PAD_EN to fill the rest of memory with NOPs after the last command.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [11:0]       cmd_imm12,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

`ifdef IMEM_LOADER_PAD_EN
  localparam loader_state_t AFTER_LAST = S_PAD;
`else
  localparam loader_state_t AFTER_LAST = S_DONE;
`endif

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W:0]   count_nxt, count_inc;
  logic              err_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] waddr_nxt;
  logic [31:0]       wdata_nxt;
  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              at_end;

  instr_encode u_encode (
    .op    (cmd_op),
    .rd    (cmd_rd),
    .rs1   (cmd_rs1),
    .imm12 (cmd_imm12),
    .word  (enc_word),
    .valid (enc_valid)
  );

  assign at_end    = (addr == LAST_ADDR);
  assign count_inc = (count == COUNT_MAX) ? count : count + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      count      <= count_nxt;
      err        <= err_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= waddr_nxt;
      imem_wdata <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    count_nxt = count;
    err_nxt   = err;
    we_nxt    = 1'b0;
    waddr_nxt = imem_addr;
    wdata_nxt = imem_wdata;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          state_nxt = S_LOAD;
          addr_nxt  = '0;
          count_nxt = '0;
          err_nxt   = 1'b0;
        end
      end

      S_LOAD: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
        if (cmd_valid) begin
          if (enc_valid) begin
            we_nxt    = 1'b1;
            waddr_nxt = addr;
            wdata_nxt = enc_word;
            count_nxt = count_inc;
            // The top word ends the session either way; the address is held, never wrapped.
            if (at_end) begin
              state_nxt = S_DONE;
              if (!cmd_last) err_nxt = 1'b1;
            end else begin
              addr_nxt = addr + ADDR_W'(1);
              if (cmd_last) state_nxt = AFTER_LAST;
            end
          end else begin
            err_nxt = 1'b1;
            if (cmd_last) state_nxt = AFTER_LAST;
          end
        end
      end

`ifdef IMEM_LOADER_PAD_EN
      S_PAD: begin
        busy      = 1'b1;
        we_nxt    = 1'b1;
        waddr_nxt = addr;
        wdata_nxt = NOP_WORD;
        count_nxt = count_inc;
        if (at_end) state_nxt = S_DONE;
        else        addr_nxt  = addr + ADDR_W'(1);
      end
`endif

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
